// File: rtl/pattern_loader_pkg.sv
// pattern_loader_pkg
// Shared definitions for the pattern buffer scan-chain master:
//   - default field width / field count of the pattern buffer
//   - FSM state encoding (also exported on the debug port of pattern_loader)
package pattern_loader_pkg;

    localparam int BUFFER_WIDTH_DEFAULT = 8;
    localparam int BUFFER_SIZE_DEFAULT  = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SHIFT  = 3'd2,
        HOLD   = 3'd3,
        FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/pattern_shifter.sv
// pattern_shifter
// Byte-wide serializer/deserializer for the pattern buffer scan chain.
// tx side is parallel-in/serial-out, MSB first; rx side is serial-in/
// parallel-out, new bits entering at the LSB.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   clear        zero the bit counter at the start of a pass
//   load         capture load_data into the tx register
//   load_data    byte to be sent
//   shift        one scan-chain shift this cycle
//   sout         serial bit coming back from the buffer
//   sin          serial bit going to the buffer (tx MSB, a flop output)
//   rx_next      rx byte as it will be after this cycle's shift
//   rx_data      rx byte register
//   last_bit     this shift is the final bit of the byte
import pattern_loader_pkg::*;

module pattern_shifter #(
    parameter int buffer_width = BUFFER_WIDTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    load,
    input  logic [buffer_width-1:0] load_data,
    input  logic                    shift,
    input  logic                    sout,
    output logic                    sin,
    output logic [buffer_width-1:0] rx_next,
    output logic [buffer_width-1:0] rx_data,
    output logic                    last_bit
);

    localparam int bit_cnt_width = (buffer_width > 1) ? $clog2(buffer_width) : 1;
    localparam logic [bit_cnt_width-1:0] last_bit_idx = bit_cnt_width'(buffer_width - 1);

    logic [buffer_width-1:0]  tx_q;
    logic [bit_cnt_width-1:0] bit_cnt_q;

    // The tx MSB drives the chain directly, so sin is registered and
    // naturally returns to 0 once all bits of the byte have been sent.
    assign sin      = tx_q[buffer_width-1];
    assign rx_next  = {rx_data[buffer_width-2:0], sout};
    assign last_bit = shift && (bit_cnt_q == last_bit_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_q      <= '0;
            rx_data   <= '0;
            bit_cnt_q <= '0;
        end else begin
            if (load) begin
                tx_q <= load_data;
            end else if (shift) begin
                tx_q <= {tx_q[buffer_width-2:0], 1'b0};
            end

            if (shift) begin
                rx_data <= rx_next;
            end

            // Counter returns to 0 on the last bit, so it never wraps mid-byte.
            if (clear || load) begin
                bit_cnt_q <= '0;
            end else if (shift) begin
                bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pattern_loader.sv
// pattern_loader
// Serial master of the pattern buffer scan chain. One pass replaces every
// field of the buffer: each byte is fetched from the load stream, shifted in
// MSB first while the old byte shifts out, and the old byte is offered on
// the unload stream. Field buffer_size-1 travels first, field 0 last.
//
// Handshakes (in_valid/in_ready, out_valid/out_ready): a byte transfers on a
// posedge where valid and ready are both high. Once out_valid is raised,
// out_data holds steady until the transfer; in_ready does not depend on
// in_valid.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 one-cycle request for a pass (honoured only in IDLE)
//   busy                  high for the whole pass, through the done cycle
//   done                  one-cycle pulse at the end of the pass
//   in_data/valid/ready   load stream
//   out_data/valid/ready  unload stream
//   ssel, sin             registered scan-chain select and data to the buffer
//   sout                  scan-chain data from the buffer
//   fsm_state             current FSM state, for debug/observation
import pattern_loader_pkg::*;

module pattern_loader #(
    parameter int buffer_width = BUFFER_WIDTH_DEFAULT,
    parameter int buffer_size  = BUFFER_SIZE_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    input  logic [buffer_width-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [buffer_width-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    ssel,
    output logic                    sin,
    input  logic                    sout,
    output state_t                  fsm_state
);

    localparam int byte_cnt_width = (buffer_size > 1) ? $clog2(buffer_size) : 1;
    localparam logic [byte_cnt_width-1:0] last_byte_idx = byte_cnt_width'(buffer_size - 1);

    state_t                    state_q;
    state_t                    state_next;
    logic [byte_cnt_width-1:0] byte_cnt_q;
    logic                      last_byte;

    logic                      clear;
    logic                      load;
    logic                      shift;
    logic                      emit;
    logic                      last_bit;
    logic [buffer_width-1:0]   rx_next;
    logic [buffer_width-1:0]   rx_data;
    logic [buffer_width-1:0]   emit_data;

    pattern_shifter #(
        .buffer_width (buffer_width)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .load      (load),
        .load_data (in_data),
        .shift     (shift),
        .sout      (sout),
        .sin       (sin),
        .rx_next   (rx_next),
        .rx_data   (rx_data),
        .last_bit  (last_bit)
    );

    assign last_byte = (byte_cnt_q == last_byte_idx);
    assign fsm_state = state_q;

    // At the end of SHIFT the final sout bit is still in flight, so the
    // byte comes from rx_next; in HOLD it has already settled in rx_data.
    assign emit_data = (state_q == SHIFT) ? rx_next : rx_data;

    always_comb begin
        state_next = state_q;
        busy       = (state_q != IDLE);
        done       = 1'b0;
        in_ready   = 1'b0;
        clear      = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        emit       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (last_bit) begin
                    // The output slot is free if empty or being emptied now.
                    if (!out_valid || out_ready) begin
                        emit = 1'b1;
                    end else begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    emit = 1'b1;
                end
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (emit) begin
            state_next = last_byte ? FINISH : FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            ssel       <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            state_q <= state_next;
            // Registered select that is high exactly in the SHIFT cycles.
            ssel    <= (state_next == SHIFT);

            if (clear) begin
                byte_cnt_q <= '0;
            end else if (emit && !last_byte) begin
                byte_cnt_q <= byte_cnt_q + 1'b1;
            end

            if (emit) begin
                out_data  <= emit_data;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pattern_loader.sv
`timescale 1ns/1ps
module tb_pattern_loader;
    import pattern_loader_pkg::*;

    localparam int W     = 8;
    localparam int N     = 32;
    localparam int CHAIN = W * N;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         busy;
    logic         done;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         ssel;
    logic         sin;
    logic         sout;
    state_t       fsm_state;

    always #5 clk = ~clk;

    pattern_loader #(
        .buffer_width (W),
        .buffer_size  (N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ssel      (ssel),
        .sin       (sin),
        .sout      (sout),
        .fsm_state (fsm_state)
    );

    // Pattern buffer model: a plain 256-bit chain, field i in bits [8i+7:8i].
    // sout is the far end (field N-1 MSB), sin enters at field 0 bit 0.
    logic [CHAIN-1:0] buf_q;
    logic [CHAIN-1:0] pre_val;
    logic             pre_en = 1'b0;

    always @(posedge clk) begin
        if (pre_en)    buf_q <= pre_val;
        else if (ssel) buf_q <= {buf_q[CHAIN-2:0], sin};
    end
    assign sout = buf_q[CHAIN-1];

    // ---------------- scoreboard state ----------------
    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic [W-1:0] in_bytes[N];

    // pass observations
    int busy_cycles, done_count, shift_cycles, ssel_viol;
    int hold_cycles, hold_ssel, stall_ssel;
    bit timed_out, aborted;

    // pass controls
    int in_stall_byte, in_stall_len, out_stall_len;
    int extra_start_cycle, abort_byte, abort_shift;
    bit rand_hs, extra_start_at_done;

    function automatic logic [CHAIN-1:0] rand_chain();
        logic [CHAIN-1:0] v;
        for (int i = 0; i < CHAIN / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic set_defaults();
        in_stall_byte       = -1;
        in_stall_len        = 0;
        out_stall_len       = 0;
        extra_start_cycle   = -1;
        extra_start_at_done = 1'b0;
        abort_byte          = -1;
        abort_shift         = 0;
        rand_hs             = 1'b0;
        timed_out           = 1'b0;
        aborted             = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [CHAIN-1:0] v);
        @(negedge clk);
        pre_val = v;
        pre_en  = 1'b1;
        @(negedge clk);
        pre_en  = 1'b0;
    endtask

    // Expected unload order: field N-1 first down to field 0.
    task automatic expect_from_chain(input logic [CHAIN-1:0] v);
        exp_q.delete();
        for (int j = 0; j < N; j++) exp_q.push_back(v[(N-1-j)*W +: W]);
    endtask

    // Runs one pass: pulses start, then each cycle samples outputs at the
    // negedge and drives inputs for the coming posedge.
    task automatic run_pass();
        int k             = 0;
        int cyc           = 0;
        int in_stall_cnt  = 0;
        int out_stall_cnt = 0;
        int shift_in_byte = 0;
        bit out_armed     = (out_stall_len > 0);
        bit out_active    = 1'b0;
        bit fin           = 1'b0;
        got_q.delete();
        busy_cycles = 0; done_count = 0; shift_cycles = 0; ssel_viol = 0;
        hold_cycles = 0; hold_ssel = 0; stall_ssel = 0;

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        while (!fin) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cyc > 3000) begin
                timed_out = 1'b1;
                break;
            end
            if (busy && !done) busy_cycles++;
            if (done) done_count++;
            if (ssel) begin
                shift_cycles++;
                shift_in_byte++;
            end
            if (ssel && (!busy || in_ready)) ssel_viol++;
            if (fsm_state == HOLD) begin
                hold_cycles++;
                if (ssel) hold_ssel++;
            end
            if (abort_byte >= 0 && ssel && k == abort_byte + 1 && shift_in_byte == abort_shift) begin
                reset     = 1'b1;
                in_valid  = 1'b0;
                out_ready = 1'b0;
                @(posedge clk);
                aborted = 1'b1;
                break;
            end
            if (cyc == extra_start_cycle) start = 1'b1;
            if (done) begin
                fin   = 1'b1;
                start = extra_start_at_done;
            end

            in_valid = 1'b0;
            if (in_ready && k < N) begin
                if (k == in_stall_byte && in_stall_cnt < in_stall_len) begin
                    in_stall_cnt++;
                    if (ssel) stall_ssel++;
                end else if (!rand_hs || $urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                end
            end
            if (in_valid) begin
                in_data       = in_bytes[k];
                k++;
                shift_in_byte = 0;
            end else begin
                in_data = W'($urandom);
            end

            out_ready = 1'b1;
            if (out_armed && out_valid) begin
                out_armed  = 1'b0;
                out_active = 1'b1;
            end
            if (out_active) begin
                if (out_stall_cnt < out_stall_len) begin
                    out_ready = 1'b0;
                    out_stall_cnt++;
                end else begin
                    out_active = 1'b0;
                end
            end else if (rand_hs) begin
                out_ready = ($urandom_range(0, 2) != 0);
            end
            if (out_valid && out_ready) got_q.push_back(out_data);
            @(posedge clk);
        end

        if (!aborted && !timed_out) begin
            repeat (4) begin
                @(negedge clk);
                start     = 1'b0;
                in_valid  = 1'b0;
                out_ready = 1'b1;
                if (out_valid) got_q.push_back(out_data);
                @(posedge clk);
            end
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_vec++; if (ssel !== 1'b0)      begin n_err++; $display("FAIL reset_ssel: got %b expected 0", ssel); end
        n_vec++; if (sin !== 1'b0)       begin n_err++; $display("FAIL reset_sin: got %b expected 0", sin); end
        n_vec++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        n_vec++; if (fsm_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, IDLE); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [CHAIN-1:0] v;
        set_defaults();
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(i);
        for (int k = 0; k < N; k++) in_bytes[k] = W'(8'hA0 + k);
        preload(v);
        run_pass();
        n_vec++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL basic_timeout: got %b expected 0", timed_out); end
        n_vec++; if (got_q.size() !== N) begin n_err++; $display("FAIL basic_out_count: got %0d expected %0d", got_q.size(), N); end
        for (int j = 0; j < N && j < got_q.size(); j++) begin
            n_vec++;
            if (got_q[j] !== W'(N - 1 - j)) begin n_err++; $display("FAIL basic_out[%0d]: got %h expected %h", j, got_q[j], W'(N - 1 - j)); end
        end
        for (int i = 0; i < N; i++) begin
            n_vec++;
            if (buf_q[i*W +: W] !== W'(8'hA0 + (N - 1 - i))) begin n_err++; $display("FAIL basic_field[%0d]: got %h expected %h", i, buf_q[i*W +: W], W'(8'hA0 + (N - 1 - i))); end
        end
        n_vec++; if (busy_cycles !== N * (W + 1)) begin n_err++; $display("FAIL basic_pass_len: got %0d expected %0d", busy_cycles, N * (W + 1)); end
        n_vec++; if (done_count !== 1)     begin n_err++; $display("FAIL basic_done_count: got %0d expected 1", done_count); end
        n_vec++; if (shift_cycles !== CHAIN) begin n_err++; $display("FAIL basic_shift_cycles: got %0d expected %0d", shift_cycles, CHAIN); end
        n_vec++; if (ssel_viol !== 0)      begin n_err++; $display("FAIL basic_ssel_outside_shift: got %0d expected 0", ssel_viol); end
    endtask

    task automatic test_in_stall();
        logic [CHAIN-1:0] v;
        set_defaults();
        in_stall_byte = 3;
        in_stall_len  = 5;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(i);
        for (int k = 0; k < N; k++) in_bytes[k] = W'(8'hA0 + k);
        preload(v);
        run_pass();
        n_vec++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL stall_timeout: got %b expected 0", timed_out); end
        n_vec++; if (stall_ssel !== 0) begin n_err++; $display("FAIL stall_ssel: got %0d expected 0", stall_ssel); end
        n_vec++; if (busy_cycles !== N * (W + 1) + 5) begin n_err++; $display("FAIL stall_pass_len: got %0d expected %0d", busy_cycles, N * (W + 1) + 5); end
        n_vec++; if (got_q.size() !== N) begin n_err++; $display("FAIL stall_out_count: got %0d expected %0d", got_q.size(), N); end
        for (int j = 0; j < N && j < got_q.size(); j++) begin
            n_vec++;
            if (got_q[j] !== W'(N - 1 - j)) begin n_err++; $display("FAIL stall_out[%0d]: got %h expected %h", j, got_q[j], W'(N - 1 - j)); end
        end
        for (int i = 0; i < N; i++) begin
            n_vec++;
            if (buf_q[i*W +: W] !== W'(8'hA0 + (N - 1 - i))) begin n_err++; $display("FAIL stall_field[%0d]: got %h expected %h", i, buf_q[i*W +: W], W'(8'hA0 + (N - 1 - i))); end
        end
    endtask

    task automatic test_out_backpressure();
        logic [CHAIN-1:0] v;
        set_defaults();
        out_stall_len = 10;
        v = rand_chain();
        for (int k = 0; k < N; k++) in_bytes[k] = W'($urandom);
        preload(v);
        expect_from_chain(v);
        run_pass();
        n_vec++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL bp_timeout: got %b expected 0", timed_out); end
        n_vec++; if ((hold_cycles > 0) !== 1'b1) begin n_err++; $display("FAIL bp_hold_entered: got %0d hold cycles expected >0", hold_cycles); end
        n_vec++; if (hold_ssel !== 0) begin n_err++; $display("FAIL bp_hold_ssel: got %0d expected 0", hold_ssel); end
        n_vec++; if (shift_cycles !== CHAIN) begin n_err++; $display("FAIL bp_shift_cycles: got %0d expected %0d", shift_cycles, CHAIN); end
        n_vec++; if (got_q.size() !== N) begin n_err++; $display("FAIL bp_out_count: got %0d expected %0d", got_q.size(), N); end
        for (int j = 0; j < N && j < got_q.size(); j++) begin
            n_vec++;
            if (got_q[j] !== exp_q[j]) begin n_err++; $display("FAIL bp_out[%0d]: got %h expected %h", j, got_q[j], exp_q[j]); end
        end
        for (int i = 0; i < N; i++) begin
            n_vec++;
            if (buf_q[i*W +: W] !== in_bytes[N-1-i]) begin n_err++; $display("FAIL bp_field[%0d]: got %h expected %h", i, buf_q[i*W +: W], in_bytes[N-1-i]); end
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [CHAIN-1:0] v;
        set_defaults();
        abort_byte  = 7;
        abort_shift = 4;
        preload(rand_chain());
        for (int k = 0; k < N; k++) in_bytes[k] = W'($urandom);
        run_pass();
        @(negedge clk);
        n_vec++; if (aborted !== 1'b1)    begin n_err++; $display("FAIL rst_mid_reached: got %b expected 1", aborted); end
        n_vec++; if (ssel !== 1'b0)       begin n_err++; $display("FAIL rst_mid_ssel: got %b expected 0", ssel); end
        n_vec++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        n_vec++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
        n_vec++; if (out_data !== 8'h00)  begin n_err++; $display("FAIL rst_mid_out_data: got %h expected 00", out_data); end
        n_vec++; if (sin !== 1'b0)        begin n_err++; $display("FAIL rst_mid_sin: got %b expected 0", sin); end
        n_vec++; if (fsm_state !== IDLE)  begin n_err++; $display("FAIL rst_mid_state: got %0d expected %0d", fsm_state, IDLE); end
        reset = 1'b0;

        set_defaults();
        v = rand_chain();
        for (int k = 0; k < N; k++) in_bytes[k] = W'($urandom);
        preload(v);
        expect_from_chain(v);
        run_pass();
        n_vec++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL rst_rerun_timeout: got %b expected 0", timed_out); end
        n_vec++; if (busy_cycles !== N * (W + 1)) begin n_err++; $display("FAIL rst_rerun_pass_len: got %0d expected %0d", busy_cycles, N * (W + 1)); end
        n_vec++; if (got_q.size() !== N) begin n_err++; $display("FAIL rst_rerun_out_count: got %0d expected %0d", got_q.size(), N); end
        for (int j = 0; j < N && j < got_q.size(); j++) begin
            n_vec++;
            if (got_q[j] !== exp_q[j]) begin n_err++; $display("FAIL rst_rerun_out[%0d]: got %h expected %h", j, got_q[j], exp_q[j]); end
        end
        for (int i = 0; i < N; i++) begin
            n_vec++;
            if (buf_q[i*W +: W] !== in_bytes[N-1-i]) begin n_err++; $display("FAIL rst_rerun_field[%0d]: got %h expected %h", i, buf_q[i*W +: W], in_bytes[N-1-i]); end
        end
    endtask

    task automatic test_start_while_busy();
        logic [CHAIN-1:0] v;
        int late_activity = 0;
        set_defaults();
        extra_start_cycle   = 50;
        extra_start_at_done = 1'b1;
        v = rand_chain();
        for (int k = 0; k < N; k++) in_bytes[k] = W'($urandom);
        preload(v);
        expect_from_chain(v);
        run_pass();
        repeat (10) begin
            @(negedge clk);
            if (busy || done) late_activity++;
        end
        n_vec++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL busy_start_timeout: got %b expected 0", timed_out); end
        n_vec++; if (done_count !== 1)   begin n_err++; $display("FAIL busy_start_done_count: got %0d expected 1", done_count); end
        n_vec++; if (late_activity !== 0) begin n_err++; $display("FAIL busy_start_restart: got %0d busy cycles expected 0", late_activity); end
        n_vec++; if (busy_cycles !== N * (W + 1)) begin n_err++; $display("FAIL busy_start_pass_len: got %0d expected %0d", busy_cycles, N * (W + 1)); end
        n_vec++; if (got_q.size() !== N) begin n_err++; $display("FAIL busy_start_out_count: got %0d expected %0d", got_q.size(), N); end
        for (int j = 0; j < N && j < got_q.size(); j++) begin
            n_vec++;
            if (got_q[j] !== exp_q[j]) begin n_err++; $display("FAIL busy_start_out[%0d]: got %h expected %h", j, got_q[j], exp_q[j]); end
        end
    endtask

    task automatic test_loopback();
        logic [W-1:0] first_bytes[N];
        set_defaults();
        for (int k = 0; k < N; k++) in_bytes[k] = (k % 2 == 0) ? 8'h55 : 8'hAA;
        first_bytes = in_bytes;
        run_pass();
        set_defaults();
        for (int k = 0; k < N; k++) in_bytes[k] = (k % 2 == 0) ? 8'hAA : 8'h55;
        run_pass();
        n_vec++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL loop_timeout: got %b expected 0", timed_out); end
        n_vec++; if (got_q.size() !== N) begin n_err++; $display("FAIL loop_out_count: got %0d expected %0d", got_q.size(), N); end
        for (int j = 0; j < N && j < got_q.size(); j++) begin
            n_vec++;
            if (got_q[j] !== first_bytes[j]) begin n_err++; $display("FAIL loop_out[%0d]: got %h expected %h", j, got_q[j], first_bytes[j]); end
        end
    endtask

    task automatic test_random();
        logic [CHAIN-1:0] v;
        for (int p = 0; p < 3; p++) begin
            set_defaults();
            rand_hs = 1'b1;
            v = rand_chain();
            for (int k = 0; k < N; k++) in_bytes[k] = W'($urandom);
            preload(v);
            expect_from_chain(v);
            run_pass();
            n_vec++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL rand%0d_timeout: got %b expected 0", p, timed_out); end
            n_vec++; if (ssel_viol !== 0)    begin n_err++; $display("FAIL rand%0d_ssel_outside_shift: got %0d expected 0", p, ssel_viol); end
            n_vec++; if (done_count !== 1)   begin n_err++; $display("FAIL rand%0d_done_count: got %0d expected 1", p, done_count); end
            n_vec++; if (got_q.size() !== N) begin n_err++; $display("FAIL rand%0d_out_count: got %0d expected %0d", p, got_q.size(), N); end
            for (int j = 0; j < N && j < got_q.size(); j++) begin
                n_vec++;
                if (got_q[j] !== exp_q[j]) begin n_err++; $display("FAIL rand%0d_out[%0d]: got %h expected %h", p, j, got_q[j], exp_q[j]); end
            end
            for (int i = 0; i < N; i++) begin
                n_vec++;
                if (buf_q[i*W +: W] !== in_bytes[N-1-i]) begin n_err++; $display("FAIL rand%0d_field[%0d]: got %h expected %h", p, i, buf_q[i*W +: W], in_bytes[N-1-i]); end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_in_stall();
        test_out_backpressure();
        test_reset_mid_shift();
        test_start_while_busy();
        test_loopback();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
